// File: rtl/addr_sweep_gen_if.sv
// Sweep control and step-stream bundle for addr_sweep_gen.
// ADDR_SWEEP_LOOP_EN adds the loop request and wrap pulse.
interface addr_sweep_gen_if #(
  parameter int ADDR_W = 14,
  parameter int LANES  = 2
);
  localparam int LW     = $clog2(LANES);
  localparam int WORD_W = ADDR_W - LW;

  logic                    start;
  logic [WORD_W-1:0]       cfg_base;
  logic [WORD_W:0]         cfg_len;
  logic                    ready;
  logic                    valid;
  logic [LANES*ADDR_W-1:0] addr;
  logic [WORD_W:0]         step_idx;
  logic                    busy;
  logic                    done;
`ifdef ADDR_SWEEP_LOOP_EN
  logic                    loop;
  logic                    wrap;

  modport master (
    input  start, cfg_base, cfg_len, ready, loop,
    output valid, addr, step_idx, busy, done, wrap
  );
  modport slave (
    output start, cfg_base, cfg_len, ready, loop,
    input  valid, addr, step_idx, busy, done, wrap
  );
`else
  modport master (
    input  start, cfg_base, cfg_len, ready,
    output valid, addr, step_idx, busy, done
  );
  modport slave (
    output start, cfg_base, cfg_len, ready,
    input  valid, addr, step_idx, busy, done
  );
`endif
endinterface

// File: rtl/addr_sweep_gen.sv
// Multi-lane address sweep generator: walks a word index for cfg_len steps, emitting {word, lane} per lane.
// Define ADDR_SWEEP_LOOP_EN to let a sweep repeat from its base while loop is held high.
module addr_sweep_gen #(
  parameter int ADDR_W     = 14,
  parameter int LANES      = 2,
  parameter int RESET_BASE = 2048
) (
  input  logic              clk,
  input  logic              reset,
  addr_sweep_gen_if.master  bus
);
  localparam int LW     = $clog2(LANES);
  localparam int WORD_W = ADDR_W - LW;
  localparam int LEN_W  = WORD_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] word, word_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [LEN_W-1:0]  step_idx, step_n;
  logic              last_step;
`ifdef ADDR_SWEEP_LOOP_EN
  logic [WORD_W-1:0] base_q, base_n;
  logic              wrap_q, wrap_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word     <= WORD_W'(RESET_BASE);
      len      <= '0;
      step_idx <= '0;
`ifdef ADDR_SWEEP_LOOP_EN
      base_q   <= WORD_W'(RESET_BASE);
      wrap_q   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      word     <= word_n;
      len      <= len_n;
      step_idx <= step_n;
`ifdef ADDR_SWEEP_LOOP_EN
      base_q   <= base_n;
      wrap_q   <= wrap_n;
`endif
    end
  end

  // len is never zero while in RUN, so len-1 cannot underflow here.
  assign last_step = (step_idx == len - LEN_W'(1));

  always_comb begin
    state_n = state;
    word_n  = word;
    len_n   = len;
    step_n  = step_idx;
`ifdef ADDR_SWEEP_LOOP_EN
    base_n  = base_q;
    wrap_n  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          word_n  = bus.cfg_base;
          len_n   = bus.cfg_len;
          step_n  = '0;
`ifdef ADDR_SWEEP_LOOP_EN
          base_n  = bus.cfg_base;
`endif
          state_n = (bus.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.ready) begin
          word_n = word + WORD_W'(1);
          step_n = step_idx + LEN_W'(1);
          if (last_step) begin
`ifdef ADDR_SWEEP_LOOP_EN
            if (bus.loop) begin
              word_n = base_q;
              step_n = '0;
              wrap_n = 1'b1;
            end else begin
              state_n = DONE;
            end
`else
            state_n = DONE;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane bits sit below the word, so each lane address is word*LANES + lane.
  always_comb begin
    bus.addr = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.addr[i*ADDR_W +: ADDR_W] = (ADDR_W'(word) << LW) | ADDR_W'(i);
    end
  end

  assign bus.valid    = (state == RUN);
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.step_idx = step_idx;
`ifdef ADDR_SWEEP_LOOP_EN
  assign bus.wrap     = wrap_q;
`endif

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Self-checking bench for addr_sweep_gen: sweep-level reference model compared every cycle plus literal anchors.
// Exercises the loop feature only when ADDR_SWEEP_LOOP_EN is defined.
module tb_addr_sweep_gen;
  localparam int ADDR_W = 14;
  localparam int LANES  = 2;
  localparam int WORDS  = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  addr_sweep_gen_if #(.ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  addr_sweep_gen #(.ADDR_W(ADDR_W), .LANES(LANES), .RESET_BASE(2048)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Sweep-level model: a launched sweep of m_len steps from m_base with m_k accepted so far.
  bit m_launched = 0;
  int m_base = 0;
  int m_len = 0;
  int m_k = 0;
  bit m_wrap = 0;

  logic [LANES*ADDR_W-1:0] acc_q[$];
  int valid_cycles = 0;
  int wrap_count = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit loopReq();
`ifdef ADDR_SWEEP_LOOP_EN
    return bus.loop;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_launched = 0;
      m_k = 0;
      m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (m_launched && m_k < m_len) begin
        if (bus.ready) begin
          m_k++;
          if (m_k == m_len && loopReq()) begin
            m_k = 0;
            m_wrap = 1;
          end
        end
      end else if (bus.start) begin
        m_launched = 1;
        m_base = int'(bus.cfg_base);
        m_len = int'(bus.cfg_len);
        m_k = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_valid;
    bit exp_done;
    int exp_word;
    exp_valid = m_launched && (m_k < m_len);
    exp_done = m_launched && (m_k >= m_len);
    exp_word = m_launched ? (m_base + m_k) % WORDS : 2048;
    checkOutput("valid", bus.valid, exp_valid);
    checkOutput("busy", bus.busy, exp_valid);
    checkOutput("done", bus.done, exp_done);
    checkOutput("step_idx", bus.step_idx, m_k);
    for (int i = 0; i < LANES; i++)
      checkOutput($sformatf("addr_lane%0d", i), bus.addr[i*ADDR_W +: ADDR_W], exp_word * LANES + i);
`ifdef ADDR_SWEEP_LOOP_EN
    checkOutput("wrap", bus.wrap, m_wrap);
    if (bus.wrap) wrap_count++;
`endif
    if (bus.valid) valid_cycles++;
    if (bus.valid && bus.ready) acc_q.push_back(bus.addr);
  end

  task automatic applyStimulus(input int base, input int len);
    @(posedge clk); #1;
    acc_q.delete();
    valid_cycles = 0;
    bus.start = 1'b1;
    bus.cfg_base = 13'(base);
    bus.cfg_len = 14'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s: done not seen, got 0 expected 1 within %0d cycles", name, budget);
  endtask

  task automatic checkAccepted(input string name, input int idx, input int lane0);
    logic [LANES*ADDR_W-1:0] a;
    a = acc_q[idx];
    checkOutput({name, "_l0"}, a[ADDR_W-1:0], lane0);
    checkOutput({name, "_l1"}, a[2*ADDR_W-1:ADDR_W], lane0 + 1);
  endtask

  initial begin
    int exp_wrap_addr[4];
    bus.start = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_len = '0;
    bus.ready = 1'b1;
`ifdef ADDR_SWEEP_LOOP_EN
    bus.loop = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    checkOutput("idle_lane0", bus.addr[13:0], 4096);
    checkOutput("idle_lane1", bus.addr[27:14], 4097);
    checkOutput("idle_valid", bus.valid, 0);
    checkOutput("idle_done", bus.done, 0);

    // Full-rate sweep of 1024 steps.
    applyStimulus(2048, 1024);
    @(negedge clk);
    checkOutput("first_valid", bus.valid, 1);
    checkOutput("first_lane0", bus.addr[13:0], 4096);
    checkOutput("first_lane1", bus.addr[27:14], 4097);
    waitDone("sweep_full", 1100);
    checkOutput("full_valid_cycles", valid_cycles, 1024);
    checkOutput("full_accepts", acc_q.size(), 1024);
    if (acc_q.size() == 1024) checkAccepted("full_last", 1023, 6142);
    checkOutput("full_step_idx", bus.step_idx, 1024);
    checkOutput("full_done", bus.done, 1);

    // Same sweep with ready toggling every cycle; order checked against base+k.
    applyStimulus(2048, 1024);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (bus.done) break;
      bus.ready = ~bus.ready;
    end
    bus.ready = 1'b1;
    checkOutput("toggle_done", bus.done, 1);
    checkOutput("toggle_accepts", acc_q.size(), 1024);
    for (int k = 0; k < acc_q.size(); k++) begin
      logic [LANES*ADDR_W-1:0] a;
      a = acc_q[k];
      if (a[ADDR_W-1:0] != 14'(2 * (2048 + k))) begin
        checkOutput("toggle_order", a[ADDR_W-1:0], 2 * (2048 + k));
        break;
      end
    end

    // Word wrap-around through 2^13.
    applyStimulus(8190, 4);
    waitDone("sweep_wrap", 20);
    exp_wrap_addr = '{16380, 16382, 0, 2};
    checkOutput("wrap_accepts", acc_q.size(), 4);
    if (acc_q.size() == 4)
      for (int k = 0; k < 4; k++) checkAccepted($sformatf("wrap_step%0d", k), k, exp_wrap_addr[k]);

    // Zero-length sweep goes straight to DONE.
    applyStimulus(5, 0);
    @(negedge clk);
    checkOutput("len0_done", bus.done, 1);
    checkOutput("len0_valid", bus.valid, 0);
    repeat (3) @(negedge clk);
    checkOutput("len0_valid_cycles", valid_cycles, 0);

    // start during RUN is ignored.
    applyStimulus(100, 20);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.cfg_base = 13'd3000;
    bus.cfg_len = 14'd5;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    waitDone("sweep_ignore", 40);
    checkOutput("ignore_accepts", acc_q.size(), 20);
    checkOutput("ignore_end_lane0", bus.addr[13:0], 240);
    checkOutput("ignore_step_idx", bus.step_idx, 20);

    // Reset mid-sweep at step 500.
    applyStimulus(2048, 1024);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.step_idx == 14'd500) break;
    end
    checkOutput("mid_step_reached", bus.step_idx, 500);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_step_idx", bus.step_idx, 0);
    checkOutput("rst_lane0", bus.addr[13:0], 4096);
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(10, 3);
    waitDone("sweep_after_rst", 20);
    checkOutput("after_rst_accepts", acc_q.size(), 3);
    checkOutput("after_rst_lane0", bus.addr[13:0], 26);

`ifdef ADDR_SWEEP_LOOP_EN
    // Looping sweep: two passes wrap, third pass ends in DONE once loop drops.
    wrap_count = 0;
    bus.loop = 1'b1;
    applyStimulus(50, 3);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wrap_count == 2) break;
    end
    @(posedge clk);
    #1 bus.loop = 1'b0;
    waitDone("sweep_loop", 20);
    checkOutput("loop_wraps", wrap_count, 2);
    checkOutput("loop_accepts", acc_q.size(), 9);
    if (acc_q.size() == 9) checkAccepted("loop_pass2_start", 3, 100);
    checkOutput("loop_end_lane0", bus.addr[13:0], 106);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
